// File: rtl/legv8_mem_pkg.sv
// Shared definitions for the LEGv8 data memory.
// Contents:
//   SZ_B/SZ_H/SZ_W/SZ_D   access-size encodings carried on the size bus
//   DEFAULT_LATENCY       default request-to-response latency in cycles
//   DEFAULT_DEPTH_WORDS   default array depth in 64-bit words
//   state_t               request FSM states (IDLE, BUSY, RESP)
//   size_lane_mask()      byte-lane mask of an access at lane 0
package legv8_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int DEFAULT_LATENCY     = 2;
  localparam int DEFAULT_DEPTH_WORDS = 256;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  // Lanes touched by an access of the given size when it starts at byte 0.
  function automatic logic [7:0] size_lane_mask(input logic [1:0] sz);
    logic [7:0] mask;
    case (sz)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/data_memory_unit_if.sv
// Request/response bus between the execute/memory stage (master) and the
// data memory (slave).
// Signals:
//   req_valid    master->slave  request present, held until accepted
//   req_ready    slave->master  memory can accept a request this cycle
//   mem_write    master->slave  request is a store (wins over mem_read)
//   mem_read     master->slave  request is a load
//   size         master->slave  00 byte, 01 half, 10 word, 11 doubleword
//   addr         master->slave  byte address
//   write_data   master->slave  store data, right-justified
//   rsp_valid    slave->master  one-cycle completion pulse
//   read_data    slave->master  zero-extended load data, held after pulse
//   misalign_err slave->master  response flag: address not size-aligned
interface data_memory_unit_if;
  import legv8_mem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  size;
  logic [63:0] addr;
  logic [63:0] write_data;
  logic        rsp_valid;
  logic [63:0] read_data;
  logic        misalign_err;

  modport master (
    output req_valid, mem_write, mem_read, size, addr, write_data,
    input  req_ready, rsp_valid, read_data, misalign_err
  );

  modport slave (
    input  req_valid, mem_write, mem_read, size, addr, write_data,
    output req_ready, rsp_valid, read_data, misalign_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for a little-endian 64-bit data word.
// Store side (request as presented):
//   i_st_size, i_st_offset  access size and addr[2:0]
//   i_st_data               right-justified store data
//   o_byte_en               lanes written by the store
//   o_st_data               store data moved onto its lanes
//   o_misalign              offset not a multiple of the access size
// Load side (request held since acceptance):
//   i_ld_size, i_ld_offset  access size and addr[2:0]
//   i_ld_word               64-bit word sampled from the array
//   o_ld_data               addressed lanes, right-justified, zero-extended
module mem_lane_align
  import legv8_mem_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [2:0]  i_st_offset,
  input  logic [63:0] i_st_data,
  output logic [7:0]  o_byte_en,
  output logic [63:0] o_st_data,
  output logic        o_misalign,
  input  logic [1:0]  i_ld_size,
  input  logic [2:0]  i_ld_offset,
  input  logic [63:0] i_ld_word,
  output logic [63:0] o_ld_data
);

  logic [5:0]  w_st_shift;
  logic [5:0]  w_ld_shift;
  logic [63:0] w_ld_shifted;
  logic [7:0]  w_ld_lanes;
  logic [63:0] w_ld_mask;

  assign w_st_shift = {i_st_offset, 3'b000};
  assign w_ld_shift = {i_ld_offset, 3'b000};

  always_comb begin
    o_misalign = 1'b0;
    case (i_st_size)
      SZ_B:    o_misalign = 1'b0;
      SZ_H:    o_misalign = i_st_offset[0];
      SZ_W:    o_misalign = |i_st_offset[1:0];
      default: o_misalign = |i_st_offset;
    endcase
  end

  // Only meaningful when aligned; misaligned requests never reach the array.
  assign o_byte_en = size_lane_mask(i_st_size) << i_st_offset;
  assign o_st_data = i_st_data << w_st_shift;

  assign w_ld_shifted = i_ld_word >> w_ld_shift;
  assign w_ld_lanes   = size_lane_mask(i_ld_size);

  // Expand the lane mask into a bit mask so unselected upper bytes read 0.
  for (genvar gi = 0; gi < 8; gi++) begin : g_ld_mask
    assign w_ld_mask[gi*8 +: 8] = {8{w_ld_lanes[gi]}};
  end

  assign o_ld_data = w_ld_shifted & w_ld_mask;

endmodule

// File: rtl/data_memory_unit.sv
// Multi-cycle LEGv8 data memory feeding the writeback select stage.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    slave side of data_memory_unit_if (request/response bus)
// Parameters:
//   DEPTH_WORDS  number of 64-bit words (power of two)
//   LATENCY      cycles from acceptance to rsp_valid (>= 1)
// A store commits at its acceptance edge; a load samples the array at its
// acceptance edge into a pending register and is steered/extended when the
// response is presented. Response data and error flag then hold until the
// next response.
module data_memory_unit
  import legv8_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
)
(
  input  logic               clk,
  input  logic               reset,
  data_memory_unit_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Counter holds at most LATENCY-2 (BUSY lasts LATENCY-1 cycles).
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t          r_state;
  logic [CW-1:0]   r_count;

  // Request information captured at acceptance.
  logic            r_pend_load;
  logic            r_pend_err;
  logic [1:0]      r_pend_size;
  logic [2:0]      r_pend_off;
  logic [63:0]     r_pend_word;

  // Response values held after the RESP cycle.
  logic [63:0]     r_hold_data;
  logic            r_hold_err;

  logic [63:0]     r_mem [DEPTH_WORDS];

  logic            w_ready;
  logic            w_accept;
  logic            w_is_access;
  logic            w_is_store;
  logic            w_is_load;
  logic            w_err;
  logic [AW-1:0]   w_idx;
  logic [7:0]      w_byte_en;
  logic [63:0]     w_st_data;
  logic            w_misalign;
  logic [63:0]     w_ld_data;
  logic [63:0]     w_rsp_data;
  logic            w_unused;

  mem_lane_align u_align (
    .i_st_size   (bus.size),
    .i_st_offset (bus.addr[2:0]),
    .i_st_data   (bus.write_data),
    .o_byte_en   (w_byte_en),
    .o_st_data   (w_st_data),
    .o_misalign  (w_misalign),
    .i_ld_size   (r_pend_size),
    .i_ld_offset (r_pend_off),
    .i_ld_word   (r_pend_word),
    .o_ld_data   (w_ld_data)
  );

  // Addresses wrap modulo the array size: the upper bits are ignored.
  assign w_idx    = bus.addr[3 +: AW];
  assign w_unused = ^bus.addr[63:3+AW];

  // Ready is gated by reset so it is low for the whole reset interval.
  assign w_ready     = (r_state == IDLE) && !reset;
  assign w_accept    = w_ready && bus.req_valid;
  assign w_is_access = bus.mem_write || bus.mem_read;
  assign w_is_store  = bus.mem_write;
  assign w_is_load   = bus.mem_read && !bus.mem_write;
  assign w_err       = w_misalign && w_is_access;

  // Array port: byte-enabled write and registered read at acceptance.
  always_ff @(posedge clk) begin
    if (w_accept && w_is_store && !w_err) begin
      for (int b = 0; b < 8; b++) begin
        if (w_byte_en[b]) begin
          r_mem[w_idx][b*8 +: 8] <= w_st_data[b*8 +: 8];
        end
      end
    end
    if (w_accept && w_is_load && !w_err) begin
      r_pend_word <= r_mem[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_pend_load <= 1'b0;
      r_pend_err  <= 1'b0;
      r_pend_size <= SZ_B;
      r_pend_off  <= '0;
      r_hold_data <= '0;
      r_hold_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pend_load <= w_is_load && !w_err;
            r_pend_err  <= w_err;
            r_pend_size <= bus.size;
            r_pend_off  <= bus.addr[2:0];
            r_count     <= CNT_LOAD;
            r_state     <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (r_count == '0) begin
            r_state <= RESP;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        RESP: begin
          r_hold_data <= w_rsp_data;
          r_hold_err  <= r_pend_err;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stores, no-ops and errors return zero data.
  assign w_rsp_data = r_pend_load ? w_ld_data : 64'd0;

  // During RESP the fresh result is presented; afterwards the held copy.
  assign bus.req_ready    = w_ready;
  assign bus.rsp_valid    = (r_state == RESP);
  assign bus.read_data    = (r_state == RESP) ? w_rsp_data : r_hold_data;
  assign bus.misalign_err = (r_state == RESP) ? r_pend_err : r_hold_err;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit (DEPTH_WORDS=256, LATENCY=2).
module tb_data_memory_unit;
  import legv8_mem_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  data_memory_unit_if bus ();

  data_memory_unit #(
    .DEPTH_WORDS (256),
    .LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request through the full IDLE-BUSY-RESP-IDLE sequence.
  task automatic txn(input string tag, input logic w, input logic r,
                     input logic [1:0] sz, input logic [63:0] a,
                     input logic [63:0] wd, input logic [63:0] exp_data,
                     input logic exp_err);
    int cyc;
    bus.req_valid  = 1'b1;
    bus.mem_write  = w;
    bus.mem_read   = r;
    bus.size       = sz;
    bus.addr       = a;
    bus.write_data = wd;
    cyc = 0;
    while (bus.req_ready !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".ready_idle"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    for (int k = 0; k < LAT - 1; k++) begin
      chk({tag, ".rsp_busy"}, 64'(bus.rsp_valid), 64'd0);
      chk({tag, ".ready_busy"}, 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, ".ready_resp"}, 64'(bus.req_ready), 64'd0);
    chk({tag, ".read_data"}, bus.read_data, exp_data);
    chk({tag, ".misalign"}, 64'(bus.misalign_err), 64'(exp_err));
    $display("txn %-12s w=%0b r=%0b size=%0d addr=%h wdata=%h -> data=%h err=%0b",
             tag, w, r, sz, a, wd, bus.read_data, bus.misalign_err);
    @(posedge clk); #1;
    chk({tag, ".rsp_drop"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, ".ready_back"}, 64'(bus.req_ready), 64'd1);
    chk({tag, ".data_held"}, bus.read_data, exp_data);
  endtask

  initial begin
    logic [8:0] ready_pat;
    int         n_acc;
    int         n_rsp;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.size       = SZ_B;
    bus.addr       = '0;
    bus.write_data = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset.read_data", bus.read_data, 64'd0);
    chk("reset.misalign", 64'(bus.misalign_err), 64'd0);
    chk("reset.ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset.ready", 64'(bus.req_ready), 64'd1);
    $display("txn reset released");

    // Basic store/load lane steering.
    txn("st_d_10", 1, 0, SZ_D, 64'h10, 64'h1122334455667788, 64'h0, 1'b0);
    txn("ld_b_11", 0, 1, SZ_B, 64'h11, 64'h0, 64'h77, 1'b0);
    txn("ld_h_12", 0, 1, SZ_H, 64'h12, 64'h0, 64'h5566, 1'b0);
    // Byte store uses only the low byte and preserves other lanes.
    txn("st_b_13", 1, 0, SZ_B, 64'h13, 64'hFFFFFFFFFFFFFFAB, 64'h0, 1'b0);
    txn("ld_d_10a", 0, 1, SZ_D, 64'h10, 64'h0, 64'h11223344AB667788, 1'b0);
    // Misaligned accesses.
    txn("ld_d_14", 0, 1, SZ_D, 64'h14, 64'h0, 64'h0, 1'b1);
    txn("st_w_16", 1, 0, SZ_W, 64'h16, 64'hCAFEBABE, 64'h0, 1'b1);
    txn("ld_d_10b", 0, 1, SZ_D, 64'h10, 64'h0, 64'h11223344AB667788, 1'b0);
    txn("ld_w_14", 0, 1, SZ_W, 64'h14, 64'h0, 64'h11223344, 1'b0);
    // Address wrap: 0x810 maps onto the same word as 0x10.
    txn("st_d_810", 1, 0, SZ_D, 64'h810, 64'hDEAD, 64'h0, 1'b0);
    txn("ld_d_10c", 0, 1, SZ_D, 64'h10, 64'h0, 64'hDEAD, 1'b0);
    // Read and write both set: behaves as a word store.
    txn("rw_w_10", 1, 1, SZ_W, 64'h10, 64'h12345678, 64'h0, 1'b0);
    txn("ld_d_10d", 0, 1, SZ_D, 64'h10, 64'h0, 64'h12345678, 1'b0);
    // No-op still completes with zero data.
    txn("noop", 0, 0, SZ_D, 64'h14, 64'h0, 64'h0, 1'b0);
    txn("ld_b_10", 0, 1, SZ_B, 64'h10, 64'h0, 64'h78, 1'b0);

    // Continuous req_valid: one acceptance every LAT+1 cycles.
    bus.req_valid = 1'b1;
    bus.mem_read  = 1'b1;
    bus.size      = SZ_B;
    bus.addr      = 64'h11;
    ready_pat = '0;
    n_acc = 0;
    n_rsp = 0;
    for (int c = 0; c < 9; c++) begin
      ready_pat = {ready_pat[7:0], bus.req_ready};
      if (bus.req_ready === 1'b1) n_acc++;
      if (bus.rsp_valid === 1'b1) n_rsp++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    chk("hold.ready_pattern", 64'(ready_pat), 64'(9'b100100100));
    chk("hold.accepts", 64'(n_acc), 64'd3);
    chk("hold.responses", 64'(n_rsp), 64'd3);
    chk("hold.read_data", bus.read_data, 64'h56);
    $display("txn hold_valid ready_pattern=%b accepts=%0d responses=%0d", ready_pat, n_acc, n_rsp);

    // Reset during BUSY of a load discards the response.
    bus.req_valid = 1'b1;
    bus.mem_read  = 1'b1;
    bus.size      = SZ_D;
    bus.addr      = 64'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    chk("rst_busy.in_busy", 64'(bus.req_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy.read_data", bus.read_data, 64'd0);
    chk("rst_busy.misalign", 64'(bus.misalign_err), 64'd0);
    chk("rst_busy.ready_in_reset", 64'(bus.req_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_busy.ready_after", 64'(bus.req_ready), 64'd1);
    n_rsp = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0) n_rsp++;
    end
    chk("rst_busy.no_rsp", 64'(n_rsp), 64'd0);
    $display("txn reset_in_busy stray_responses=%0d", n_rsp);
    // Committed array contents survive reset.
    txn("ld_d_10e", 0, 1, SZ_D, 64'h10, 64'h0, 64'h12345678, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
